// File: rtl/bus_timer.sv
// Bus-attached programmable interval timer: ctrl/divisor/counter registers with a one-cycle ack.
// Define BUS_TIMER_WAITSTATE_EN to insert one wait state between strobe and acknowledge.
module bus_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [3:2]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef BUS_TIMER_WAITSTATE_EN
    S_WAIT = 2'd1,
`endif
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        commit;

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux;
  logic        ien_q, ien_d;
  logic        expired_q, expired_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] counter_q, counter_d;
  logic        wr_ctrl, wr_div, expire;

  // Bus FSM: commit marks the edge that enters ACK; writes and read capture happen there only.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stb) begin
`ifdef BUS_TIMER_WAITSTATE_EN
          state_d = S_WAIT;
`else
          state_d = S_ACK;
          commit  = 1'b1;
`endif
        end
      end
`ifdef BUS_TIMER_WAITSTATE_EN
      S_WAIT: begin
        state_d = S_ACK;
        commit  = 1'b1;
      end
`endif
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ctrl = commit & we & (addr == 2'd0);
  assign wr_div  = commit & we & (addr == 2'd1);

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0:    rd_mux = {30'd0, expired_q, ien_q};
      2'd1:    rd_mux = divisor_q;
      2'd2:    rd_mux = counter_q;
      default: rd_mux = '0;
    endcase
  end

  // Read data is only non-zero during ACK, so data_out needs no gating by ack.
  assign rdata_d = (commit & ~we) ? rd_mux : '0;

  always_comb begin
    divisor_d = divisor_q;
    counter_d = counter_q;
    expire    = 1'b0;
    if (wr_div) begin
      divisor_d = data_in;
      counter_d = data_in;
    end else if (counter_q > 32'd1) begin
      counter_d = counter_q - 32'd1;
    end else if (counter_q == 32'd1) begin
      counter_d = divisor_q;
      expire    = 1'b1;
    end
  end

  // Expiry is applied after the clear so it wins a same-cycle collision.
  always_comb begin
    ien_d     = ien_q;
    expired_d = expired_q;
    if (wr_ctrl) begin
      ien_d = data_in[0];
      if (!data_in[1]) expired_d = 1'b0;
    end
    if (expire) expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rdata_q   <= '0;
      ien_q     <= 1'b0;
      expired_q <= 1'b0;
      divisor_q <= '1;
      counter_q <= '1;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ien_q     <= ien_d;
      expired_q <= expired_d;
      divisor_q <= divisor_d;
      counter_q <= counter_d;
    end
  end

  assign ack      = (state_q == S_ACK);
  assign data_out = rdata_q;
  assign irq      = expired_q & ien_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: bus accesses push expected read data, ack pops and compares.
module tb_bus_timer;

`ifdef BUS_TIMER_WAITSTATE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  bus_timer dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one cycle after the ack edge with the bus back in IDLE; ccyc is the ack edge.
  task automatic bus_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input string tag, output int ccyc);
    sb_t e;
    int  start;
    bit  got;
    e.rd   = !w;
    e.data = exp_rd;
    sb_q.push_back(e);
    stb = 1'b1; we = w; addr = a; data_in = d;
    start = cyc;
    got   = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack === 1'b1) got = 1'b1;
      else chk({tag, "/idle_dout"}, data_out, 32'd0);
    end
    chk({tag, "/ack_seen"}, 32'(got), 32'd1);
    ccyc = cyc;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    if (got) begin
      chk({tag, "/latency"}, 32'(cyc - start), 32'(LAT));
      if (e.rd) chk({tag, "/rdata"}, data_out, e.data);
    end
    stb = 1'b0; we = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "/ack_drop"}, 32'(ack), 32'd0);
  endtask

  function automatic logic [31:0] cnt_model(input int e, input int dc);
    return 32'(4 - ((e - dc) % 4));
  endfunction

  initial begin
    int  r, c, dc, s, start, first, acks, hits;
    sb_t e;

    rst = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    rst = 1'b1;
    r = cyc;
    bus_access(1'b0, 2'd2, '0, 32'hFFFF_FFFF - 32'(cyc + LAT - 1 - r), "rst_cnt", c);

    // handshake: strobe stays high through the ACK cycle, must not re-trigger
    stb = 1'b1; we = 1'b0; addr = 2'd1;
    e.rd = 1'b1; e.data = 32'hFFFF_FFFF;
    sb_q.push_back(e);
    start = cyc; acks = 0; first = -1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) begin
          first = cyc - start;
          e = sb_q.pop_front();
          chk("hs_rdata", data_out, e.data);
        end
      end else if (acks > 0) begin
        stb = 1'b0;
      end
    end
    stb = 1'b0;
    chk("hs_acks", 32'(acks), 32'd1);
    chk("hs_latency", 32'(first), 32'(LAT));

    // periodic expiry with divisor 4
    bus_access(1'b1, 2'd0, 32'd1, '0, "ien", c);
    bus_access(1'b1, 2'd1, 32'd4, '0, "div4", dc);
    wait_until(dc + 3);
    chk("exp_pre_irq", 32'(irq), 32'd0);
    wait_until(dc + 4);
    chk("exp_irq1", 32'(irq), 32'd1);
    bus_access(1'b1, 2'd0, 32'd1, '0, "clr", c);
    chk("clr_irq", 32'(irq), 32'd0);
    wait_until(dc + 7);
    chk("clr_hold_irq", 32'(irq), 32'd0);
    wait_until(dc + 8);
    chk("exp_irq2", 32'(irq), 32'd1);

    // clear lands on the reload edge: expiry wins
    wait_until(dc + 12 - LAT);
    bus_access(1'b1, 2'd0, 32'd1, '0, "coll", c);
    chk("coll_edge", 32'(c), 32'(dc + 12));
    chk("coll_irq", 32'(irq), 32'd1);
    s = cyc;
    bus_access(1'b0, 2'd2, '0, cnt_model(s + LAT - 1, dc), "cnt4", c);
    bus_access(1'b0, 2'd0, '0, 32'd3, "ctrl_exp", c);

    // stopped timer
    bus_access(1'b1, 2'd1, 32'd0, '0, "div0", c);
    bus_access(1'b1, 2'd0, 32'd1, '0, "clr0", c);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (irq !== 1'b0) hits++;
    end
    chk("stop_irq_never", 32'(hits), 32'd0);
    bus_access(1'b0, 2'd2, '0, 32'd0, "stop_cnt_a", c);
    bus_access(1'b0, 2'd2, '0, 32'd0, "stop_cnt_b", c);
    bus_access(1'b0, 2'd2, '0, 32'd0, "stop_cnt_c", c);
    bus_access(1'b1, 2'd0, 32'hFFFF_FFFF, '0, "ctrl_ones", c);
    bus_access(1'b0, 2'd0, '0, 32'd1, "ctrl_rd", c);
    bus_access(1'b1, 2'd2, 32'h0000_0055, '0, "wr_cnt", c);
    bus_access(1'b0, 2'd2, '0, 32'd0, "cnt_ro", c);
    bus_access(1'b1, 2'd3, 32'hA5A5_A5A5, '0, "wr_rsv", c);
    bus_access(1'b0, 2'd3, '0, 32'd0, "rsv_rd", c);
    bus_access(1'b0, 2'd1, '0, 32'd0, "div_rd0", c);

    // reset during a pending divisor write; strobe still high at release is a fresh read
    stb = 1'b1; we = 1'b1; addr = 2'd1; data_in = 32'd7;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_dout", data_out, 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ack2", 32'(ack), 32'd0);
    rst = 1'b1;
    r = cyc;
    e.rd = 1'b1; e.data = 32'hFFFF_FFFF;
    sb_q.push_back(e);
    acks = 0;
    for (int i = 0; i < 6 && acks == 0; i++) begin
      @(posedge clk);
      #1;
      if (ack === 1'b1) acks = 1;
    end
    chk("mid_ack_seen", 32'(acks), 32'd1);
    e = sb_q.pop_front();
    if (acks != 0) begin
      chk("mid_latency", 32'(cyc - r), 32'(LAT));
      chk("mid_div", data_out, e.data);
    end
    stb = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ack_drop", 32'(ack), 32'd0);
    bus_access(1'b0, 2'd0, '0, 32'd0, "mid_ctrl", c);
    bus_access(1'b0, 2'd2, '0, 32'hFFFF_FFFF - 32'(cyc + LAT - 1 - r), "mid_cnt", c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port stb, input, 1 bit: bus strobe from the initiator; held high until ack is seen.
REQ-004 SHALL have port we, input, 1 bit: write enable, qualified by stb.
REQ-005 SHALL have port addr, input, 2 bits [3:2]: word address of the register (0 ctrl, 1 divisor, 2 counter, 3 reserved).
REQ-006 SHALL have port data_in, input, 32 bits: write data, qualified by stb & we.
REQ-007 SHALL have port data_out, output, 32 bits: read data, valid only while ack is high.
REQ-008 SHALL have port ack, output, 1 bit: one-cycle acknowledge pulse.
REQ-009 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-010 SHALL implement a bus state machine with states IDLE, (WAIT if configured), ACK; IDLE->ACK when stb=1, ACK->IDLE unconditionally.
REQ-011 SHALL keep ack=1 for exactly one cycle per access, with ack rising on the first clock edge after stb is sampled high in IDLE (base latency 1 cycle).
REQ-012 SHALL ignore stb during ACK so that a held strobe is not counted twice; a new access starts only from IDLE.
REQ-013 SHALL commit a write on the same edge that raises ack, and SHALL capture read data into data_out on that edge.
REQ-014 SHALL drive data_out=0 whenever ack=0.
REQ-015 SHALL define ctrl: bit0 ien (R/W), bit1 expired (read; writing 0 clears it, writing 1 has no effect), bits 31:2 read 0.
REQ-016 SHALL treat a divisor write as loading both divisor and counter with data_in.
REQ-017 SHALL make counter read-only; writes to addresses 2 and 3 are acknowledged and discarded, and reads of address 3 return 0.
REQ-018 SHALL decrement counter by 1 each cycle when counter > 1.
REQ-019 SHALL, when counter = 1, reload counter from divisor and set expired on the same edge.
REQ-020 SHALL hold counter at 0 when it is 0 (divisor 0 = timer stopped, never expires).
REQ-021 SHALL let a divisor write take precedence over the decrement or reload in the same cycle.
REQ-022 SHALL let expiry take precedence over a clearing ctrl write in the same cycle (expired ends at 1).
REQ-023 SHALL drive irq = expired AND ien, with no additional registering.

Reset
REQ-024 SHALL, while rst=0, force ack=0, data_out=0, irq=0, ien=0, expired=0, divisor=0xFFFFFFFF, counter=0xFFFFFFFF, and the state machine to IDLE.
REQ-025 SHALL, on reset asserted mid-access, abandon the access with no register update; after release, an still-high stb is treated as a new access.

Configuration
REQ-026 SHALL honour macro BUS_TIMER_WAITSTATE_EN: when defined, IDLE->WAIT->ACK, so ack rises 2 edges after stb is sampled; when undefined, WAIT is absent and the latency is 1 edge.
REQ-027 SHALL, with BUS_TIMER_WAITSTATE_EN defined, commit writes and capture reads on the edge entering ACK, not the edge entering WAIT.

Verification
REQ-028 Reset: hold rst=0 for 3 cycles -> ack=0, irq=0; first read of addr 2 returns 0xFFFFFFFF minus the cycles elapsed since release.
REQ-029 Handshake: stb=1, we=0, addr=1 held for 5 cycles -> exactly one ack pulse, 1 cycle after stb (2 with macro), data_out=0xFFFFFFFF.
REQ-030 Expiry: write divisor=4, then ctrl=1 -> expired sets every 4 cycles, irq=1; write ctrl=0x1 (bit1=0) -> irq=0 until the next expiry.
REQ-031 Collision: clear expired on the exact cycle counter=1 -> expired=1 and irq stays 1.
REQ-032 Stop: write divisor=0 -> counter reads 0 repeatedly and expired never sets over 100 cycles.
REQ-033 Mid-access reset: assert rst in the cycle after stb with write divisor=7 -> divisor reads 0xFFFFFFFF after recovery.
